// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and the write-request bundle
// used by the writeback port arbiter, its FIFO and its interface.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline writeback + LL result inputs, register-file
// write outputs, stall and pending mask. WBARB_PERF_EN adds PERF_CONFLICTS.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  WB_V;
    logic                  WB_REG_WEN;
    logic [REG_ADDR_W-1:0] WB_DR;
    logic [XLEN-1:0]       WB_RES;
    logic                  LL_V;
    logic [REG_ADDR_W-1:0] LL_DR;
    logic [XLEN-1:0]       LL_RES;
    logic                  LL_READY;
    logic                  OUT_DE_REG_WEN;
    logic [REG_ADDR_W-1:0] OUT_DE_DR;
    logic [XLEN-1:0]       OUT_DE_Data;
    logic                  OUT_PIPE_STALL;
    logic [NUM_REGS-1:0]   OUT_LL_PENDING;
`ifdef WBARB_PERF_EN
    logic [31:0]           PERF_CONFLICTS;
`endif

    modport master (
`ifdef WBARB_PERF_EN
        input  PERF_CONFLICTS,
`endif
        output WB_V, WB_REG_WEN, WB_DR, WB_RES,
        output LL_V, LL_DR, LL_RES,
        input  LL_READY, OUT_DE_REG_WEN, OUT_DE_DR, OUT_DE_Data,
        input  OUT_PIPE_STALL, OUT_LL_PENDING
    );

    modport slave (
`ifdef WBARB_PERF_EN
        output PERF_CONFLICTS,
`endif
        input  WB_V, WB_REG_WEN, WB_DR, WB_RES,
        input  LL_V, LL_DR, LL_RES,
        output LL_READY, OUT_DE_REG_WEN, OUT_DE_DR, OUT_DE_Data,
        output OUT_PIPE_STALL, OUT_LL_PENDING
    );

endinterface

// File: rtl/wb_port_arbiter_ll_fifo.sv
// wb_ll_fifo: DEPTH x {dr,data} synchronous FIFO for LL results.
// Ports: push/pop, full/empty/count, head entry, per-entry valid and dr.
module wb_ll_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_dr,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [REG_ADDR_W-1:0] head_dr,
    output logic [XLEN-1:0]       head_data,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [REG_ADDR_W-1:0] ent_dr [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PONE = 1;
    localparam logic [PW:0]   CONE = 1;
    localparam logic [PW:0]   CFULL = (PW+1)'(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic [REG_ADDR_W-1:0] dr_q   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic                  push_ok, pop_ok;
    logic [PW-1:0]         off;

    assign full      = (count_q == CFULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_dr   = dr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign ent_dr    = dr_q;

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PONE : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + CONE;
        else if (!push_ok && pop_ok) count_d = count_q - CONE;
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        ent_valid = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, off} < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            dr_q[wr_ptr_q]   <= push_dr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between pipeline WB and LL results.
// Ports: CLK, RESET (sync, active-low), bus (slave). WBARB_PERF_EN adds PERF_CONFLICTS.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic CLK,
    input  logic RESET,
    wb_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CONE      = 1;
    localparam logic [CW-1:0] CNT_TRIP  = CW'(DEPTH - 1);
    localparam logic [WW-1:0] WONE      = 1;
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_TRIP = WW'(MAX_WAIT - 1);

    logic                  pw, ll_xfer, bypass, push, pop;
    logic                  full, empty;
    logic [CW-1:0]         count, count_nx;
    logic [REG_ADDR_W-1:0] head_dr;
    logic [XLEN-1:0]       head_data;
    logic [DEPTH-1:0]      ent_valid;
    logic [REG_ADDR_W-1:0] ent_dr [DEPTH];
    logic [NUM_REGS-1:0]   pending;

    wb_req_t       out_q, out_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d;

    wb_ll_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (push),
        .push_dr   (bus.LL_DR),
        .push_data (bus.LL_RES),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_dr   (head_dr),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_dr    (ent_dr)
    );

    always_comb begin
        pw      = bus.WB_V && bus.WB_REG_WEN && (bus.WB_DR != '0);
        ll_xfer = bus.LL_V && !full;
        pop     = !pw && !empty;
        // An LL result skips the FIFO only when nothing else wants the port.
        bypass  = !pw && empty && ll_xfer;
        push    = ll_xfer && !bypass;

        out_d.valid = 1'b0;
        out_d.dr    = out_q.dr;
        out_d.data  = out_q.data;
        unique case (1'b1)
            pw: begin
                out_d.valid = 1'b1;
                out_d.dr    = bus.WB_DR;
                out_d.data  = bus.WB_RES;
            end
            pop: begin
                out_d.valid = (head_dr != '0);
                out_d.dr    = head_dr;
                out_d.data  = head_data;
            end
            bypass: begin
                out_d.valid = (bus.LL_DR != '0);
                out_d.dr    = bus.LL_DR;
                out_d.data  = bus.LL_RES;
            end
            default: ;
        endcase

        count_nx = count;
        if (push && !pop) count_nx = count + CONE;
        else if (!push && pop) count_nx = count - CONE;

        if (empty || pop) wait_d = '0;
        else if (wait_q != WAIT_MAX) wait_d = wait_q + WONE;
        else wait_d = wait_q;

        // Stall is judged on the state being latched at this edge.
        stall_d = (wait_d >= WAIT_TRIP) || (count_nx >= CNT_TRIP);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pending[ent_dr[i]] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_q   <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign bus.LL_READY       = !full;
    assign bus.OUT_DE_REG_WEN = out_q.valid;
    assign bus.OUT_DE_DR      = out_q.dr;
    assign bus.OUT_DE_Data    = out_q.data;
    assign bus.OUT_PIPE_STALL = stall_q;
    assign bus.OUT_LL_PENDING = pending;

`ifdef WBARB_PERF_EN
    logic [31:0] conflicts_q, conflicts_d;

    always_comb begin
        conflicts_d = conflicts_q;
        if (pw && !empty && (conflicts_q != 32'hFFFF_FFFF))
            conflicts_d = conflicts_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) conflicts_q <= '0;
        else conflicts_q <= conflicts_d;
    end

    assign bus.PERF_CONFLICTS = conflicts_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed test of wb_port_arbiter (DEPTH=4, MAX_WAIT=8).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WB_V = 0; bus.WB_REG_WEN = 0; bus.WB_DR = 0; bus.WB_RES = 0;
        bus.LL_V = 0; bus.LL_DR = 0; bus.LL_RES = 0;
    endtask

    task automatic pw_on(input logic [4:0] dr, input logic [63:0] d);
        bus.WB_V = 1; bus.WB_REG_WEN = 1; bus.WB_DR = dr; bus.WB_RES = d;
    endtask

    task automatic ll_on(input logic [4:0] dr, input logic [63:0] d);
        bus.LL_V = 1; bus.LL_DR = dr; bus.LL_RES = d;
    endtask

    task automatic test_reset();
        rst_n = 0;
        pw_on(5'd3, 64'h1);
        ll_on(5'd2, 64'h2);
        tick();
        tick();
        total++;
        if (bus.OUT_DE_REG_WEN !== 1'b0) begin
            bad++; $display("FAIL rst_wen got=%b exp=0", bus.OUT_DE_REG_WEN);
        end
        total++;
        if (bus.OUT_DE_DR !== 5'd0) begin
            bad++; $display("FAIL rst_dr got=%0d exp=0", bus.OUT_DE_DR);
        end
        total++;
        if (bus.OUT_DE_Data !== 64'd0) begin
            bad++; $display("FAIL rst_data got=%h exp=0", bus.OUT_DE_Data);
        end
        total++;
        if (bus.OUT_PIPE_STALL !== 1'b0) begin
            bad++; $display("FAIL rst_stall got=%b exp=0", bus.OUT_PIPE_STALL);
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'd0) begin
            bad++; $display("FAIL rst_pend got=%h exp=0", bus.OUT_LL_PENDING);
        end
        total++;
        if (bus.LL_READY !== 1'b1) begin
            bad++; $display("FAIL rst_ready got=%b exp=1", bus.LL_READY);
        end
        rst_n = 1;
        idle();
        tick();
        total++;
        if (bus.OUT_DE_REG_WEN !== 1'b0) begin
            bad++; $display("FAIL rst_rel_wen got=%b exp=0", bus.OUT_DE_REG_WEN);
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'd0) begin
            bad++; $display("FAIL rst_rel_pend got=%h exp=0", bus.OUT_LL_PENDING);
        end
    endtask

    task automatic test_bypass();
        ll_on(5'd5, 64'hAB);
        tick();
        idle();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL byp_wr got=%b/%0d exp=1/5",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR);
        end
        total++;
        if (bus.OUT_DE_Data !== 64'hAB) begin
            bad++; $display("FAIL byp_data got=%h exp=ab", bus.OUT_DE_Data);
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'd0) begin
            bad++; $display("FAIL byp_pend got=%h exp=0", bus.OUT_LL_PENDING);
        end
        tick();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
            !== {1'b0, 5'd5, 64'hAB}) begin
            bad++; $display("FAIL byp_hold got=%b/%0d/%h exp=0/5/ab",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
        end
    endtask

    task automatic test_priority();
        logic [4:0]  exp_dr [3] = '{5'd3, 5'd3, 5'd3};
        logic [31:0] exp_pd [3] = '{32'h80, 32'h280, 32'h280};
        pw_on(5'd3, 64'h11);
        ll_on(5'd7, 64'h22);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) ll_on(5'd9, 64'h33);
            tick();
            if (c == 1) bus.LL_V = 0;
            total++;
            if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
                !== {1'b1, exp_dr[c], 64'h11}) begin
                bad++; $display("FAIL prio_wr[%0d] got=%b/%0d/%h exp=1/3/11", c,
                                bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
            end
            total++;
            if (bus.OUT_LL_PENDING !== exp_pd[c]) begin
                bad++; $display("FAIL prio_pend[%0d] got=%h exp=%h", c,
                                bus.OUT_LL_PENDING, exp_pd[c]);
            end
            total++;
            if (bus.OUT_PIPE_STALL !== 1'b0) begin
                bad++; $display("FAIL prio_stall[%0d] got=%b exp=0", c,
                                bus.OUT_PIPE_STALL);
            end
        end
`ifdef WBARB_PERF_EN
        total++;
        if (bus.PERF_CONFLICTS !== 32'd2) begin
            bad++; $display("FAIL prio_perf got=%0d exp=2", bus.PERF_CONFLICTS);
        end
`endif
        idle();
        tick();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
            !== {1'b1, 5'd7, 64'h22}) begin
            bad++; $display("FAIL prio_x7 got=%b/%0d/%h exp=1/7/22",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'h200) begin
            bad++; $display("FAIL prio_pend_x7 got=%h exp=200", bus.OUT_LL_PENDING);
        end
        tick();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
            !== {1'b1, 5'd9, 64'h33}) begin
            bad++; $display("FAIL prio_x9 got=%b/%0d/%h exp=1/9/33",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'h0) begin
            bad++; $display("FAIL prio_pend_end got=%h exp=0", bus.OUT_LL_PENDING);
        end
        tick();
        total++;
        if (bus.OUT_DE_REG_WEN !== 1'b0) begin
            bad++; $display("FAIL prio_idle got=%b exp=0", bus.OUT_DE_REG_WEN);
        end
    endtask

    task automatic test_full();
        logic [63:0] d;
        pw_on(5'd3, 64'h11);
        for (int i = 0; i < 4; i++) begin
            ll_on(5'(10 + i), 64'hA0 + 64'(i));
            tick();
            total++;
            if (bus.OUT_PIPE_STALL !== (i >= 2)) begin
                bad++; $display("FAIL full_stall[%0d] got=%b exp=%b", i,
                                bus.OUT_PIPE_STALL, (i >= 2));
            end
            total++;
            if (bus.LL_READY !== (i < 3)) begin
                bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", i,
                                bus.LL_READY, (i < 3));
            end
            total++;
            if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR} !== {1'b1, 5'd3}) begin
                bad++; $display("FAIL full_pw[%0d] got=%b/%0d exp=1/3", i,
                                bus.OUT_DE_REG_WEN, bus.OUT_DE_DR);
            end
        end
        ll_on(5'd14, 64'hA4);
        tick();
        total++;
        if (bus.OUT_LL_PENDING !== 32'h3C00) begin
            bad++; $display("FAIL full_pend got=%h exp=3c00", bus.OUT_LL_PENDING);
        end
        total++;
        if (bus.LL_READY !== 1'b0) begin
            bad++; $display("FAIL full_ready_hold got=%b exp=0", bus.LL_READY);
        end
        bus.WB_V = 0;
        tick();
        bus.LL_V = 0;
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
            !== {1'b1, 5'd10, 64'hA0}) begin
            bad++; $display("FAIL full_pop0 got=%b/%0d/%h exp=1/10/a0",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'h3800) begin
            bad++; $display("FAIL full_nopass got=%h exp=3800", bus.OUT_LL_PENDING);
        end
        total++;
        if ({bus.LL_READY, bus.OUT_PIPE_STALL} !== 2'b11) begin
            bad++; $display("FAIL full_pop0_rs got=%b%b exp=11",
                            bus.LL_READY, bus.OUT_PIPE_STALL);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            d = 64'hA0 + 64'(i);
            total++;
            if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
                !== {1'b1, 5'(10 + i), d}) begin
                bad++; $display("FAIL full_pop%0d got=%b/%0d/%h exp=1/%0d/%h", i,
                                bus.OUT_DE_REG_WEN, bus.OUT_DE_DR,
                                bus.OUT_DE_Data, 10 + i, d);
            end
            total++;
            if (bus.OUT_PIPE_STALL !== 1'b0) begin
                bad++; $display("FAIL full_drain_stall%0d got=%b exp=0", i,
                                bus.OUT_PIPE_STALL);
            end
        end
        total++;
        if (bus.OUT_LL_PENDING !== 32'h0) begin
            bad++; $display("FAIL full_pend_end got=%h exp=0", bus.OUT_LL_PENDING);
        end
        tick();
        total++;
        if (bus.OUT_DE_REG_WEN !== 1'b0) begin
            bad++; $display("FAIL full_idle got=%b exp=0", bus.OUT_DE_REG_WEN);
        end
    endtask

    task automatic test_starvation();
        pw_on(5'd3, 64'h11);
        ll_on(5'd20, 64'h55);
        tick();
        bus.LL_V = 0;
        total++;
        if (bus.OUT_LL_PENDING !== 32'h0010_0000) begin
            bad++; $display("FAIL starve_pend got=%h exp=100000", bus.OUT_LL_PENDING);
        end
        for (int k = 0; k <= 6; k++) begin
            total++;
            if (bus.OUT_PIPE_STALL !== 1'b0) begin
                bad++; $display("FAIL starve_early[%0d] got=%b exp=0", k,
                                bus.OUT_PIPE_STALL);
            end
            tick();
        end
        total++;
        if (bus.OUT_PIPE_STALL !== 1'b1) begin
            bad++; $display("FAIL starve_rise got=%b exp=1", bus.OUT_PIPE_STALL);
        end
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR} !== {1'b1, 5'd3}) begin
            bad++; $display("FAIL starve_pw got=%b/%0d exp=1/3",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR);
        end
        bus.WB_V = 0;
        tick();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
            !== {1'b1, 5'd20, 64'h55}) begin
            bad++; $display("FAIL starve_wr got=%b/%0d/%h exp=1/20/55",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
        end
        total++;
        if (bus.OUT_PIPE_STALL !== 1'b0) begin
            bad++; $display("FAIL starve_clear got=%b exp=0", bus.OUT_PIPE_STALL);
        end
        idle();
        tick();
    endtask

    task automatic test_zero_dr();
        pw_on(5'd0, 64'h99);
        ll_on(5'd4, 64'h44);
        tick();
        idle();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data}
            !== {1'b1, 5'd4, 64'h44}) begin
            bad++; $display("FAIL zero_byp got=%b/%0d/%h exp=1/4/44",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR, bus.OUT_DE_Data);
        end
        ll_on(5'd0, 64'h77);
        tick();
        idle();
        total++;
        if (bus.OUT_DE_REG_WEN !== 1'b0) begin
            bad++; $display("FAIL zero_ll_byp got=%b exp=0", bus.OUT_DE_REG_WEN);
        end
        pw_on(5'd3, 64'h11);
        ll_on(5'd0, 64'h78);
        tick();
        idle();
        total++;
        if ({bus.OUT_DE_REG_WEN, bus.OUT_DE_DR} !== {1'b1, 5'd3}) begin
            bad++; $display("FAIL zero_pw got=%b/%0d exp=1/3",
                            bus.OUT_DE_REG_WEN, bus.OUT_DE_DR);
        end
        tick();
        total++;
        if (bus.OUT_DE_REG_WEN !== 1'b0) begin
            bad++; $display("FAIL zero_ll_pop got=%b exp=0", bus.OUT_DE_REG_WEN);
        end
        total++;
        if ({bus.OUT_LL_PENDING, bus.LL_READY} !== {32'h0, 1'b1}) begin
            bad++; $display("FAIL zero_end got=%h/%b exp=0/1",
                            bus.OUT_LL_PENDING, bus.LL_READY);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_priority();
        test_full();
        test_starvation();
        test_zero_dr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
